// File: rtl/pipe_ctrl.sv
// Pipeline controller for the 5-stage LC-3b datapath: buffer load/flush
// sequencing, cache response tracking, load-use bubbles and event counters.
module pipe_ctrl #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 imem_resp,
    input  logic                 dmem_req,
    input  logic                 dmem_resp,
    input  logic [2:0]           id_src1,
    input  logic [2:0]           id_src2,
    input  logic                 id_uses_src2,
    input  logic [2:0]           ex_dest,
    input  logic                 ex_mem_read,
    input  logic                 mem_br_taken,
    input  logic                 cnt_clr,
    output logic                 imem_read,
    output logic                 dmem_issue,
    output logic                 load_pc,
    output logic                 load_if_id,
    output logic                 load_id_ex,
    output logic                 load_ex_mem,
    output logic                 load_mem_wb,
    output logic                 flush_if_id,
    output logic                 flush_id_ex,
    output logic                 flush_ex_mem,
    output logic [CNT_WIDTH-1:0] stall_count,
    output logic [CNT_WIDTH-1:0] flush_count
);

    typedef enum logic {RUN, WAIT} state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_t               state_reg;
    logic                 imem_done_reg;
    logic                 dmem_done_reg;
    logic [CNT_WIDTH-1:0] stall_cnt_reg;
    logic [CNT_WIDTH-1:0] flush_cnt_reg;

    logic imem_ok;
    logic dmem_ok;
    logic advance;
    logic load_use;
    logic stall_cyc;
    logic branch_cyc;
    logic bubble_cyc;
    logic stall_inc;

    assign imem_ok    = imem_resp | imem_done_reg;
    assign dmem_ok    = ~dmem_req | dmem_resp | dmem_done_reg;
    assign advance    = imem_ok & dmem_ok;
    assign load_use   = ex_mem_read &
                        ((ex_dest == id_src1) | (id_uses_src2 & (ex_dest == id_src2)));
    assign stall_cyc  = ~advance;
    assign branch_cyc = advance & mem_br_taken;
    // A taken branch squashes the ID instruction, so its hazard is moot.
    assign bubble_cyc = advance & ~mem_br_taken & load_use;
    assign stall_inc  = stall_cyc | bubble_cyc;

    assign stall_count = stall_cnt_reg;
    assign flush_count = flush_cnt_reg;

    always_comb begin
        imem_read    = 1'b0;
        dmem_issue   = 1'b0;
        load_pc      = 1'b0;
        load_if_id   = 1'b0;
        load_id_ex   = 1'b0;
        load_ex_mem  = 1'b0;
        load_mem_wb  = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_ex_mem = 1'b0;
        if (reset_n) begin
            imem_read  = ~imem_done_reg;
            dmem_issue = dmem_req & ~dmem_done_reg;
            if (branch_cyc) begin
                load_pc      = 1'b1;
                load_if_id   = 1'b1;
                load_id_ex   = 1'b1;
                load_ex_mem  = 1'b1;
                load_mem_wb  = 1'b1;
                flush_if_id  = 1'b1;
                flush_id_ex  = 1'b1;
                flush_ex_mem = 1'b1;
            end else if (bubble_cyc) begin
                load_id_ex   = 1'b1;
                flush_id_ex  = 1'b1;
                load_ex_mem  = 1'b1;
                load_mem_wb  = 1'b1;
            end else if (advance) begin
                load_pc      = 1'b1;
                load_if_id   = 1'b1;
                load_id_ex   = 1'b1;
                load_ex_mem  = 1'b1;
                load_mem_wb  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= RUN;
            imem_done_reg <= 1'b0;
            dmem_done_reg <= 1'b0;
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            case (state_reg)
                RUN:     if (!advance) state_reg <= WAIT;
                WAIT:    if (advance)  state_reg <= RUN;
                default: state_reg <= RUN;
            endcase

            if (bubble_cyc) begin
                // PC and IF/ID hold, so the fetched word is still valid next cycle.
                imem_done_reg <= 1'b1;
                dmem_done_reg <= 1'b0;
            end else if (advance) begin
                imem_done_reg <= 1'b0;
                dmem_done_reg <= 1'b0;
            end else begin
                imem_done_reg <= imem_done_reg | imem_resp;
                dmem_done_reg <= dmem_done_reg | (dmem_req & dmem_resp);
            end

            if (cnt_clr) begin
                stall_cnt_reg <= '0;
                flush_cnt_reg <= '0;
            end else begin
                if (stall_inc && stall_cnt_reg != CNT_MAX)
                    stall_cnt_reg <= stall_cnt_reg + 1'b1;
                if (branch_cyc && flush_cnt_reg != CNT_MAX)
                    flush_cnt_reg <= flush_cnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus random traffic checked against
// a cycle-level reference model of the controller's rules.
module tb_pipe_ctrl;
    localparam int W = 4;
    localparam int MAXC = (1 << W) - 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic imem_resp = 1'b0, dmem_req = 1'b0, dmem_resp = 1'b0;
    logic [2:0] id_src1 = 3'd0, id_src2 = 3'd0, ex_dest = 3'd0;
    logic id_uses_src2 = 1'b0, ex_mem_read = 1'b0, mem_br_taken = 1'b0, cnt_clr = 1'b0;
    logic imem_read, dmem_issue, load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
    logic flush_if_id, flush_id_ex, flush_ex_mem;
    logic [W-1:0] stall_count, flush_count;

    int total = 0;
    int bad = 0;

    // reference model state
    bit m_idone, m_ddone;
    int m_stall, m_flush;

    pipe_ctrl #(.CNT_WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n), .imem_resp(imem_resp), .dmem_req(dmem_req),
        .dmem_resp(dmem_resp), .id_src1(id_src1), .id_src2(id_src2),
        .id_uses_src2(id_uses_src2), .ex_dest(ex_dest), .ex_mem_read(ex_mem_read),
        .mem_br_taken(mem_br_taken), .cnt_clr(cnt_clr), .imem_read(imem_read),
        .dmem_issue(dmem_issue), .load_pc(load_pc), .load_if_id(load_if_id),
        .load_id_ex(load_id_ex), .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] outs();
        return {imem_read, dmem_issue, load_pc, load_if_id, load_id_ex, load_ex_mem,
                load_mem_wb, flush_if_id, flush_id_ex, flush_ex_mem};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        imem_resp = 1'b1; dmem_req = 1'b0; dmem_resp = 1'b0;
        id_src1 = 3'd1; id_src2 = 3'd2; id_uses_src2 = 1'b0; ex_dest = 3'd5;
        ex_mem_read = 1'b0; mem_br_taken = 1'b0; cnt_clr = 1'b0;
    endtask

    // Called just after a falling edge with inputs applied; checks this cycle
    // against the model, then advances model and clock to the next falling edge.
    task automatic cyc(input string tag);
        bit iok, dok, adv, haz;
        logic [7:0] ld;
        logic [9:0] exp;
        int kind; // 0 stall, 1 branch, 2 bubble, 3 normal
        #1;
        iok = imem_resp || m_idone;
        dok = !dmem_req || dmem_resp || m_ddone;
        adv = iok && dok;
        haz = ex_mem_read && (ex_dest == id_src1 || (id_uses_src2 && ex_dest == id_src2));
        if (!adv) kind = 0;
        else if (mem_br_taken) kind = 1;
        else if (haz) kind = 2;
        else kind = 3;
        case (kind)
            0: ld = 8'b00000_000;
            1: ld = 8'b11111_111;
            2: ld = 8'b00111_010;
            default: ld = 8'b11111_000;
        endcase
        exp = {!m_idone, dmem_req && !m_ddone, ld};
        check(tag, {6'd0, outs()}, {6'd0, exp});
        check({tag, ".stall_cnt"}, {12'd0, stall_count}, m_stall[15:0]);
        check({tag, ".flush_cnt"}, {12'd0, flush_count}, m_flush[15:0]);
        $display("cyc %-12s kind=%0d outs=%b stall=%0d flush=%0d", tag, kind, outs(),
                 stall_count, flush_count);
        @(posedge clk);
        if (cnt_clr) begin
            m_stall = 0; m_flush = 0;
        end else begin
            if ((kind == 0 || kind == 2) && m_stall < MAXC) m_stall++;
            if (kind == 1 && m_flush < MAXC) m_flush++;
        end
        case (kind)
            0: begin
                m_idone = m_idone || imem_resp;
                m_ddone = m_ddone || (dmem_req && dmem_resp);
            end
            2: begin m_idone = 1; m_ddone = 0; end
            default: begin m_idone = 0; m_ddone = 0; end
        endcase
        @(negedge clk);
    endtask

    task automatic clear_cnt();
        idle(); cnt_clr = 1'b1; cyc("clr"); cnt_clr = 1'b0;
    endtask

    initial begin
        m_idone = 0; m_ddone = 0; m_stall = 0; m_flush = 0;
        idle();
        #1;
        check("reset.outs", {6'd0, outs()}, 16'd0);
        check("reset.stall", {12'd0, stall_count}, 16'd0);
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;

        // 1: steady fetch, no hazards
        for (int i = 0; i < 4; i++) cyc("steady");
        check("steady.loads", {11'd0, load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb}, 16'h1f);
        check("steady.stall0", {12'd0, stall_count}, 16'd0);

        // 2: D-cache stall, imem at cycle 1, dmem at cycle 3
        idle(); dmem_req = 1'b1; imem_resp = 1'b0; cyc("dstall.c0");
        imem_resp = 1'b1; cyc("dstall.c1");
        imem_resp = 1'b0; cyc("dstall.c2");
        check("dstall.imem_read_drop", {15'd0, imem_read}, 16'd0);
        dmem_resp = 1'b1; cyc("dstall.c3");
        idle(); cyc("dstall.after");
        check("dstall.count3", {12'd0, stall_count}, 16'd3);
        clear_cnt();

        // 3: load-use bubble
        idle(); ex_mem_read = 1'b1; ex_dest = 3'd3; id_src1 = 3'd3; cyc("lu.bubble");
        idle(); imem_resp = 1'b0; cyc("lu.next");
        check("lu.count1", {12'd0, stall_count}, 16'd1);
        clear_cnt();

        // 4: branch overrides load-use
        idle(); ex_mem_read = 1'b1; ex_dest = 3'd2; id_src2 = 3'd2; id_uses_src2 = 1'b1;
        mem_br_taken = 1'b1; cyc("br.lu");
        idle(); cyc("br.after");
        check("br.flush1", {12'd0, flush_count}, 16'd1);
        check("br.stall0", {12'd0, stall_count}, 16'd0);
        clear_cnt();

        // 5: branch waits out a 2-cycle D-cache stall
        idle(); dmem_req = 1'b1; mem_br_taken = 1'b1; cyc("brst.c0");
        imem_resp = 1'b0; cyc("brst.c1");
        dmem_resp = 1'b1; cyc("brst.c2");
        idle(); cyc("brst.after");
        check("brst.flush1", {12'd0, flush_count}, 16'd1);
        check("brst.stall2", {12'd0, stall_count}, 16'd2);
        clear_cnt();

        // 6: saturation, clear, reset mid-WAIT
        idle(); dmem_req = 1'b1;
        for (int i = 0; i < MAXC + 1; i++) cyc("sat");
        cyc("sat.hold");
        check("sat.max", {12'd0, stall_count}, MAXC[15:0]);
        cnt_clr = 1'b1; cyc("sat.clr"); cnt_clr = 1'b0;
        cyc("sat.cleared");
        check("sat.zero_after_clr", {12'd0, stall_count}, 16'd1);
        reset_n = 1'b0; #1;
        check("rst.mid_wait.outs", {6'd0, outs()}, 16'd0);
        check("rst.mid_wait.cnt", {12'd0, stall_count}, 16'd0);
        m_idone = 0; m_ddone = 0; m_stall = 0; m_flush = 0;
        @(negedge clk); reset_n = 1'b1;
        idle(); imem_resp = 1'b0; cyc("rst.refetch");
        check("rst.imem_read", {15'd0, imem_read}, 16'd1);
        idle(); cyc("rst.run");

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            imem_resp    = ($urandom_range(0, 2) != 0);
            dmem_req     = ($urandom_range(0, 2) == 0);
            dmem_resp    = ($urandom_range(0, 2) == 0);
            id_src1      = 3'($urandom_range(0, 7));
            id_src2      = 3'($urandom_range(0, 7));
            id_uses_src2 = 1'($urandom_range(0, 1));
            ex_dest      = 3'($urandom_range(0, 7));
            ex_mem_read  = ($urandom_range(0, 2) == 0);
            mem_br_taken = ($urandom_range(0, 5) == 0);
            cnt_clr      = ($urandom_range(0, 60) == 0);
            cyc("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline controller for the 5-stage LC-3b datapath.
- Drives the load/flush pair of every inter-stage buffer (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC load.
- Tracks single-cycle I-cache/D-cache response pulses across multi-cycle stalls, inserts load-use bubbles, and squashes wrong-path stages on a taken branch resolved in MEM.
- Keeps saturating stall and flush event counters for performance debug.

Parameters:
CNT_WIDTH, 16, width of stall_count and flush_count (saturating)

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
imem_resp  input  1  I-cache response pulse (one cycle)
dmem_req  input  1  MEM stage needs a data access (from EX/MEM control word)
dmem_resp  input  1  D-cache response pulse (one cycle)
id_src1  input  3  ID stage source register 1
id_src2  input  3  ID stage source register 2
id_uses_src2  input  1  ID instruction reads src2
ex_dest  input  3  EX stage destination register
ex_mem_read  input  1  EX instruction is LDR/LDB/LDI
mem_br_taken  input  1  br_out of EX/MEM buffer (branch/JMP/JSR/TRAP taken)
cnt_clr  input  1  synchronous clear of both counters
imem_read  output  1  fetch request to I-cache
dmem_issue  output  1  data request to D-cache
load_pc  output  1  PC register load
load_if_id, load_id_ex, load_ex_mem, load_mem_wb  output  1 each  buffer load enables
flush_if_id, flush_id_ex, flush_ex_mem  output  1 each  buffer flush (zero) enables
stall_count  output  CNT_WIDTH  cycles lost to memory stall or bubble
flush_count  output  CNT_WIDTH  taken-branch squash events

Behaviour:
- State: FSM {RUN, WAIT}, flags imem_done and dmem_done, two counters. Reset (async, reset_n=0): state RUN, flags 0, counters 0. All load_*/flush_* and dmem_issue read 0 while reset_n=0; imem_read=0.
- Flag semantics:
  - imem_ok = imem_resp | imem_done
  - dmem_ok = !dmem_req | dmem_resp | dmem_done
  - advance = imem_ok & dmem_ok
- Request outputs (combinational, reset_n=1):
  - imem_read = !imem_done
  - dmem_issue = dmem_req & !dmem_done
  - A satisfied side is never re-requested.
- Flag update each edge:
  - If advance: both flags clear.
  - Else: imem_done |= imem_resp; dmem_done |= (dmem_req & dmem_resp).
- FSM: RUN -> WAIT when !advance. WAIT -> RUN when advance. WAIT holds otherwise.
- Priority 1, memory stall (!advance): all load_* = 0, all flush_* = 0. The pipeline freezes and pending branch or hazard decisions are deferred. stall_count +1.
- Priority 2, taken branch (advance & mem_br_taken): all load_* = 1, load_pc = 1; flush_if_id = flush_id_ex = flush_ex_mem = 1. flush_count +1. A coincident load-use is ignored because the squashed instruction is discarded.
- Priority 3, load-use (advance & ex_mem_read & (ex_dest==id_src1 | (id_uses_src2 & ex_dest==id_src2))):
  - load_pc = 0, load_if_id = 0, load_id_ex = 1, flush_id_ex = 1 (bubble into EX); load_ex_mem = load_mem_wb = 1.
  - stall_count +1. Exactly one bubble results, because the next cycle EX holds the flushed word (ex_mem_read = 0).
  - The fetch completed this cycle is not re-requested: imem_done stays set for the held cycle, and advance is not treated as consumed for IF.
- Normal advance: all load_* = 1, flush_* = 0.
- Counters:
  - Saturate at 2^CNT_WIDTH-1, no wrap.
  - cnt_clr has priority over increment and gives 0 next cycle.
- Reset asserted mid-stall discards the flags; after release the FSM is in RUN and the fetch is re-requested.

Test Plan:
- Reset release with imem_resp pulsing every cycle, no hazards -> every load_* = 1 each cycle; counters remain 0.
- dmem_req=1, dmem_resp at cycle 3, imem_resp at cycle 1 -> FSM enters WAIT. Loads are 0 for cycles 0-2 and 1 at cycle 3. imem_read drops after cycle 1 and dmem_issue after cycle 3. stall_count=3.
- ex_mem_read=1, ex_dest=3, id_src1=3, no stall -> one cycle with load_pc=0, load_if_id=0, flush_id_ex=1. Next cycle is a normal advance. stall_count=1.
- mem_br_taken=1 together with a load-use match -> three flushes plus load_pc=1, no bubble; flush_count=1, stall_count=0.
- mem_br_taken=1 during a 2-cycle D-cache stall -> no flush during the stall; flush on the advance cycle; flush_count=1, stall_count=2.
- Preload stall_count to max (CNT_WIDTH=4, 15 stall cycles) plus one more stall -> stays 15. Then cnt_clr -> 0. Then reset_n low mid-WAIT -> outputs immediately 0, FSM in RUN after release.
